// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - 512-byte data memory stage with byte lanes, registered loads and alignment checks
module data_mem_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2 ** (ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              misaligned,
    output logic              wr,
    output logic              rd
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_misaligned;
    logic              r_wr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_aligned;
    logic              w_load_legal;
    logic              w_store_legal;
    logic              w_load_ok;
    logic              w_store_ok;
    logic              w_bad;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ext;

    assign w_idle = (r_state == S_IDLE);

    // Funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        w_aligned = 1'b1;
        case (Funct3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_store_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    assign w_load_legal  = w_store_legal || (Funct3 == 3'b100) || (Funct3 == 3'b101);

    assign w_store_ok = w_idle && MemWrite && w_store_legal && w_aligned;
    assign w_load_ok  = w_idle && MemRead && !MemWrite && w_load_legal && w_aligned;
    // A simultaneous read+write is always flagged even when the store itself is legal
    assign w_bad      = w_idle && ((MemRead && MemWrite) ||
                                   ((MemRead || MemWrite) && !w_store_ok && !w_load_ok));

    assign stall = reset && w_load_ok;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wr_data;
        case (Funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wr_data[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wr_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wr_data;
            end
        endcase
    end

    // Asynchronous array read so a load right after a store sees the committed word
    assign w_word = r_mem[addr[ADDR_W-1:2]];
    assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (addr[1:0])
            2'b00: w_byte = w_word[7:0];
            2'b01: w_byte = w_word[15:8];
            2'b10: w_byte = w_word[23:16];
            2'b11: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_ext = w_word;
        case (Funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[addr[ADDR_W-1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_wr         <= 1'b0;
        end else begin
            r_rd_valid   <= w_load_ok;
            r_misaligned <= w_bad;
            r_wr         <= w_store_ok;
            if (w_load_ok) begin
                r_rd_data <= w_ext;
            end
            case (r_state)
                S_IDLE:    r_state <= w_load_ok ? S_RD_WAIT : S_IDLE;
                S_RD_WAIT: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd         = r_rd_valid;
    assign misaligned = r_misaligned;
    assign wr         = r_wr;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - directed self-checking bench for data_mem_unit
module tb_data_mem_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic        misaligned;
    logic        wr;
    logic        rd;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_mem_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .stall      (stall),
        .misaligned (misaligned),
        .wr         (wr),
        .rd         (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        MemWrite = 1'b1; MemRead = 1'b0; Funct3 = f3; addr = a; wr_data = d;
        #1 check({tag, ".stall"}, {31'd0, stall}, 32'd0);
        step();
        drop();
        check({tag, ".wr"}, {31'd0, wr}, 32'd1);
        check({tag, ".mis"}, {31'd0, misaligned}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] exp);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = f3; addr = a;
        #1 check({tag, ".stall"}, {31'd0, stall}, 32'd1);
        step();
        drop();
        check({tag, ".vld"}, {30'd0, rd_valid, rd}, 32'd3);
        check({tag, ".data"}, rd_data, exp);
        step();
        check({tag, ".vld_end"}, {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic do_bad(input string tag, input logic r, input logic w, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] d, input logic exp_wr);
        MemRead = r; MemWrite = w; Funct3 = f3; addr = a; wr_data = d;
        #1 check({tag, ".stall"}, {31'd0, stall}, 32'd0);
        step();
        drop();
        check({tag, ".mis"}, {31'd0, misaligned}, 32'd1);
        check({tag, ".vld"}, {31'd0, rd_valid}, 32'd0);
        check({tag, ".wr"}, {31'd0, wr}, {31'd0, exp_wr});
        step();
        check({tag, ".mis_end"}, {30'd0, misaligned, rd_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; addr = '0; wr_data = '0;
        step();
        step();
        check("rst.data", rd_data, 32'd0);
        check("rst.flags", {27'd0, rd_valid, stall, misaligned, wr, rd}, 32'd0);
        reset = 1'b1;
        step();

        MemRead = 1'b1; Funct3 = F_W; addr = 9'h000;
        #1 check("lw0.stall", {31'd0, stall}, 32'd1);
        step();
        drop();
        check("lw0.vld", {30'd0, rd_valid, rd}, 32'd3);
        check("lw0.stall_wait", {31'd0, stall}, 32'd0);
        step();

        MemRead = 1'b1; Funct3 = F_W; addr = 9'h000;
        step();
        drop();
        reset = 1'b0;
        #1;
        check("abort.data", rd_data, 32'd0);
        check("abort.vld", {31'd0, rd_valid}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("abort.after", {31'd0, rd_valid}, 32'd0);

        do_store("sw10", F_W, 9'h010, 32'hDEADBEEF);
        do_load("lb13", F_B, 9'h013, 32'hFFFFFFDE);
        do_load("lbu13", F_BU, 9'h013, 32'h000000DE);
        do_load("lh12", F_H, 9'h012, 32'hFFFFDEAD);
        do_load("lhu10", F_HU, 9'h010, 32'h0000BEEF);

        do_store("sb11", F_B, 9'h011, 32'h0000007F);
        do_load("lw10a", F_W, 9'h010, 32'hDEAD7FEF);
        do_store("sh12", F_H, 9'h012, 32'h00001234);
        do_load("lw10b", F_W, 9'h010, 32'h12347FEF);

        do_store("sw30", F_W, 9'h030, 32'h00000000);
        do_bad("lw22", 1'b1, 1'b0, F_W, 9'h022, 32'h0, 1'b0);
        check("lw22.keep", rd_data, 32'h12347FEF);
        do_bad("sh31", 1'b0, 1'b1, F_H, 9'h031, 32'h0000FFFF, 1'b0);
        check("sh31.keep", rd_data, 32'h12347FEF);
        do_load("lw30", F_W, 9'h030, 32'h00000000);

        do_bad("ill_ld", 1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 1'b0);
        do_bad("ill_st", 1'b0, 1'b1, F_BU, 9'h010, 32'h0, 1'b0);
        do_load("lw10c", F_W, 9'h010, 32'h12347FEF);

        do_store("sw1fc", F_W, 9'h1FC, 32'hA5A5A5A5);
        do_load("raw1fc", F_W, 9'h1FC, 32'hA5A5A5A5);
        do_store("sb1ff", F_B, 9'h1FF, 32'h00000080);
        do_load("lb1ff", F_B, 9'h1FF, 32'hFFFFFF80);
        do_load("lbu1ff", F_BU, 9'h1FF, 32'h00000080);

        do_bad("both40", 1'b1, 1'b1, F_W, 9'h040, 32'h11111111, 1'b1);
        do_load("lw40", F_W, 9'h040, 32'h11111111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Data-memory stage directly downstream of the core datapath. It consumes the datapath's memory request (MemRead/MemWrite, Funct3, 9-bit byte address, store data) and returns load data to the writeback path. It holds a byte-addressed 512-byte array organised as 128 x 32-bit words with byte-lane writes. Loads have a one-cycle registered latency, signalled with a stall handshake; the unit sign- or zero-extends sub-word loads and detects misaligned accesses.

Parameters:
DATA_W, 32, data width in bits (fixed at 32 for lane logic)
ADDR_W, 9, byte-address width
DEPTH, 2**(ADDR_W-2) = 128, number of 32-bit words

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
MemRead  input  1  load request, sampled each cycle in IDLE
MemWrite  input  1  store request, sampled each cycle in IDLE
Funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
addr  input  ADDR_W  byte address
wr_data  input  DATA_W  store data, right-aligned
rd_data  output  DATA_W  extended load result, registered
rd_valid  output  1  one-cycle pulse when rd_data is updated
stall  output  1  core must hold the PC and pipeline while this is 1
misaligned  output  1  one-cycle pulse on a misaligned or illegal access
wr  output  1  one-cycle pulse when a store commits (trace)
rd  output  1  one-cycle pulse when a load completes (trace)

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; rd_data=0; rd_valid, stall, misaligned, wr and rd are all 0. Array contents are not cleared. Reset during RD_WAIT aborts the load; no rd_valid follows.
- FSM states: IDLE, RD_WAIT.
- IDLE, MemWrite=1, aligned: the byte lanes are written at the clock edge. Address/lane mapping:
  - word index = addr[ADDR_W-1:2]
  - SB: lane addr[1:0] gets wr_data[7:0]
  - SH: lanes {addr[1],0} and {addr[1],1} get wr_data[15:0]
  - SW: all lanes
  - wr pulses in the next cycle. No stall. FSM stays in IDLE.
- IDLE, MemRead=1, aligned: stall=1 combinationally in the same cycle. The word is captured at the edge, and the FSM moves to RD_WAIT.
- RD_WAIT:
  - rd_data holds the extracted and extended value; rd_valid=1, rd=1, stall=0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Next state is IDLE. A new request is not accepted in RD_WAIT; it is sampled in the following IDLE cycle.
- Load-to-use latency: request in cycle N, data valid in cycle N+1.
- rd_data holds its value until the next load completes. Stores do not alter it.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No array write and no read; rd_data is unchanged.
  - misaligned pulses for 1 cycle (registered, cycle N+1). No stall.
- Illegal Funct3 (011, 110, 111, or 1xx with a store): same handling as misaligned.
- MemRead and MemWrite both 1: the store is performed if legal, the read is dropped, and misaligned pulses to flag the conflict.
- Read-after-write to the same word in consecutive cycles: the load returns the newly written data, since the write commits at the edge before the read sample.
- Address wrap: none. The full 9-bit space maps to 128 words; the top address 0x1FF is valid for SB/LB.

Test Plan:
- Reset then LW @0x000 -> stall=1 in cycle 0; rd_valid=1 in cycle 1; rd_data is the initial array value. Asserting reset=0 mid-RD_WAIT -> rd_data=0, no rd_valid.
- SW 0xDEADBEEF @0x010, then LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x010 -> 0x0000BEEF.
- SB 0x7F @0x011 over 0xDEADBEEF, then LW @0x010 -> 0xDEAD7FEF. SH 0x1234 @0x012, then LW -> 0x12347FEF.
- LW @0x022 and SH @0x031 -> misaligned pulses; memory is unchanged; rd_data keeps its prior value; stall stays 0.
- SW 0xA5A5A5A5 @0x1FC in cycle N, LW @0x1FC in cycle N+1 -> rd_data=0xA5A5A5A5 in cycle N+2.
- MemRead=MemWrite=1, SW 0x11111111 @0x040 -> word written, no rd_valid, misaligned=1. A subsequent LW @0x040 returns 0x11111111.
